pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS32 pipeline (IF/ID/EX/MEM/WB, no forwarding).
- Keeps an internal scoreboard of in-flight destination registers and stalls ID on read-after-write hazards.
- Flushes wrong-path instructions when a branch resolves taken in MEM.
- Sequences the multi-cycle HI/LO multiplier and stalls dependent instructions until it is idle.

Parameters:
MULT_LATENCY, 4, cycles from Mult_Start until HI/LO are written (range 1-15).
REGFILE_WRITE_THROUGH, 1, 1 = register file forwards the WB write to same-cycle ID reads, so WB is not a hazard source.
STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
Clk  in  1  pipeline clock.
Reset  in  1  asynchronous, active-high reset.
Rs_ID  in  5  Instruction_ID[25:21].
Rt_ID  in  5  Instruction_ID[20:16].
Uses_Rs_ID  in  1  ID instruction reads rs.
Uses_Rt_ID  in  1  ID instruction reads rt.
Dest_Reg_ID  in  5  destination register after RegDst selection.
RegWrite_ID  in  1  ID instruction writes the register file.
Mult_ID  in  1  ID instruction is mult/multu.
MfHiLo_ID  in  1  ID instruction is mfhi/mflo.
PCSrc_MEM  in  1  branch taken, resolved in MEM.
PC_Write_En  out  1  PC register load enable.
IF_ID_Write_En  out  1  IF/ID register load enable.
IF_ID_Flush  out  1  IF/ID loads a NOP.
ID_EX_Bubble  out  1  ID/EX loads a NOP with all control bits zeroed.
EX_MEM_Flush  out  1  EX/MEM loads a NOP.
Mult_Start  out  1  one-cycle pulse; the multiplier latches its operands.
Mult_Done  out  1  one-cycle pulse in the cycle HI/LO are written.
HiLo_Busy  out  1  a multiply is in flight or running.
Stall_Cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard: three registered entries, sb_ex, sb_mem and sb_wb. Each holds {v, reg[4:0], mul}. All entries reset to 0.
- issue = !stall && !PCSrc_MEM.
- Each cycle:
  - sb_ex <= issue ? {RegWrite_ID && Dest_Reg_ID!=0, Dest_Reg_ID, Mult_ID} : 0.
  - sb_mem <= PCSrc_MEM ? 0 : sb_ex.
  - sb_wb <= sb_mem.
- match(r) is true when r!=0 and r equals the reg of any valid entry among sb_ex and sb_mem. sb_wb is also checked when REGFILE_WRITE_THROUGH=0.
- raw = (Uses_Rs_ID && match(Rs_ID)) || (Uses_Rt_ID && match(Rt_ID)).
- mbusy = (mul_cnt!=0) || sb_ex.mul || sb_mem.mul.
- stall = raw || ((Mult_ID || MfHiLo_ID) && mbusy).
- Outputs are combinational from registered state and ID/MEM inputs. Priority: flush over stall over normal.
  - Flush (PCSrc_MEM=1): PC_Write_En=1, IF_ID_Write_En=1, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Flush=1. Any stall is ignored that cycle.
  - Stall: PC_Write_En=0, IF_ID_Write_En=0, ID_EX_Bubble=1; both flush outputs 0.
  - Normal: both write enables 1; all flush/bubble outputs 0.
- Multiplier sequencing:
  - Mult_Start = sb_mem.mul, i.e. the multiply has reached MEM and can no longer be squashed.
  - On Mult_Start, the 4-bit counter mul_cnt loads MULT_LATENCY. Otherwise it decrements while nonzero.
  - Mult_Done = (mul_cnt==1).
  - HiLo_Busy = mbusy.
  - A flush in the same cycle as Mult_Start does not cancel that multiply (it is older than the branch).
- Stall_Cycles increments in each cycle where stall && !PCSrc_MEM, and saturates at all-ones.
- Reset (at any time, including mid-multiply): scoreboard cleared, mul_cnt=0, Stall_Cycles=0.
  - Outputs during reset: PC_Write_En=1, IF_ID_Write_En=1, IF_ID_Flush=0, ID_EX_Bubble=0, EX_MEM_Flush=0, Mult_Start=0, Mult_Done=0, HiLo_Busy=0.
- Register $0 never causes a hazard.
- A stalled instruction re-evaluates every cycle. Hazard latency without write-through is at most 3 stall cycles; with write-through it is at most 2.

Decomposition:
- Shared package mips_pkg holds:
  - Scoreboard entry struct {v, reg, mul}.
  - Constant REG_ZERO = 5'd0.
  - NOP encoding 32'h0000_0000.
- One natural sub-module: hazard_scoreboard, holding the three-entry shift register and the match logic. Multiplier counter and output priority logic stay in the top module.

Test Plan:
- Register write followed by a dependent read: issue add $3 (RegWrite_ID=1, Dest 3); next cycle ID has Uses_Rs=1, Rs=3, WRITE_THROUGH=1 -> exactly 2 stall cycles (PC_Write_En=0, ID_EX_Bubble=1), then issue; Stall_Cycles=2.
- Register $0 and unused fields: Dest=0 writer followed by a reader of $0 -> no stall. Rt=3 with Uses_Rt=0 after a $3 writer -> no stall.
- Taken branch flush: PCSrc_MEM=1 while ID has a RAW hazard -> flush outputs all 1, PC_Write_En=1. Next cycle sb_ex and sb_mem are empty and the hazard is gone; Stall_Cycles unchanged.
- Multiply sequencing: issue mult, MULT_LATENCY=4; mfhi follows in ID -> Mult_Start pulses 2 cycles after issue and Mult_Done pulses 4 cycles after that. mfhi stalls 6 cycles and issues the cycle after Mult_Done.
- Multiply squashed by a branch: mult in EX when PCSrc_MEM=1 -> Mult_Start never asserts and HiLo_Busy=0 the next cycle.
- Reset: assert Reset mid-multiply (mul_cnt=3) with a pending hazard -> outputs return to reset values immediately (asynchronously); after release, an independent instruction issues with no stall.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 pipeline sequencing logic.
// The scoreboard entry describes one in-flight instruction: whether it
// writes a GPR, which one, and whether it is a HI/LO multiply.
package mips_pkg;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic       v;    // writes a nonzero GPR
    logic [4:0] dst;  // destination register number
    logic       mul;  // mult/multu heading for the HI/LO unit
  } sb_entry_t;

  // $zero is hard-wired and never a hazard source.
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  // Encoding loaded into pipeline registers when they are flushed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Number of stages tracked behind ID: EX, MEM, WB.
  localparam int SB_DEPTH = 3;

  // True when a stage holding register dst_r (valid flag v_r) produces
  // the value that source register src_r wants to read.
  function automatic logic reg_hit(input logic v_r, input logic [4:0] dst_r,
                                   input logic [4:0] src_r);
    return v_r && (src_r != REG_ZERO) && (dst_r == src_r);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Three-stage destination scoreboard (EX, MEM, WB) plus the RAW match logic.
// An entry enters EX only when ID actually issues; a taken branch in MEM
// squashes the two younger stages (EX and the entry moving into MEM).
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter bit WRITE_THROUGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic       flush,
  input  sb_entry_t  id_entry,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  output logic       raw,
  output logic       ex_mul,
  output logic       mem_mul
);

  sb_entry_t  sb_ex_reg;
  sb_entry_t  sb_mem_reg;
  // WB only matters for GPR hazards, so its mul flag is not kept.
  logic       sb_wb_v_reg;
  logic [4:0] sb_wb_dst_reg;

  // Per-stage views so the match logic can be generated uniformly.
  logic       stage_v   [SB_DEPTH];
  logic [4:0] stage_dst [SB_DEPTH];
  logic       stage_chk [SB_DEPTH];
  logic [SB_DEPTH-1:0] hit_rs;
  logic [SB_DEPTH-1:0] hit_rt;

  // Shift the scoreboard one stage per cycle; flush clears what enters MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_ex_reg     <= '0;
      sb_mem_reg    <= '0;
      sb_wb_v_reg   <= 1'b0;
      sb_wb_dst_reg <= REG_ZERO;
    end else begin
      sb_ex_reg     <= issue ? id_entry : '0;
      sb_mem_reg    <= flush ? '0 : sb_ex_reg;
      sb_wb_v_reg   <= sb_mem_reg.v;
      sb_wb_dst_reg <= sb_mem_reg.dst;
    end
  end

  assign stage_v[0]   = sb_ex_reg.v;
  assign stage_dst[0] = sb_ex_reg.dst;
  assign stage_chk[0] = 1'b1;
  assign stage_v[1]   = sb_mem_reg.v;
  assign stage_dst[1] = sb_mem_reg.dst;
  assign stage_chk[1] = 1'b1;
  assign stage_v[2]   = sb_wb_v_reg;
  assign stage_dst[2] = sb_wb_dst_reg;
  // With a write-through register file the WB write reaches ID the same
  // cycle, so WB never needs to hold an instruction back.
  assign stage_chk[2] = !WRITE_THROUGH;

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      assign hit_rs[gi] = stage_chk[gi] && reg_hit(stage_v[gi], stage_dst[gi], rs);
      assign hit_rt[gi] = stage_chk[gi] && reg_hit(stage_v[gi], stage_dst[gi], rt);
    end
  endgenerate

  assign raw     = (uses_rs && (|hit_rs)) || (uses_rt && (|hit_rt));
  assign ex_mul  = sb_ex_reg.mul;
  assign mem_mul = sb_mem_reg.mul;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencing controller for the 5-stage MIPS32 pipeline without
// forwarding: RAW stalls from the scoreboard, taken-branch flushes from MEM,
// HI/LO multiplier sequencing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_LATENCY          = 4,
  parameter bit REGFILE_WRITE_THROUGH = 1'b1,
  parameter int STALL_CNT_W           = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [4:0]             Rs_ID,
  input  logic [4:0]             Rt_ID,
  input  logic                   Uses_Rs_ID,
  input  logic                   Uses_Rt_ID,
  input  logic [4:0]             Dest_Reg_ID,
  input  logic                   RegWrite_ID,
  input  logic                   Mult_ID,
  input  logic                   MfHiLo_ID,
  input  logic                   PCSrc_MEM,
  output logic                   PC_Write_En,
  output logic                   IF_ID_Write_En,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Bubble,
  output logic                   EX_MEM_Flush,
  output logic                   Mult_Start,
  output logic                   Mult_Done,
  output logic                   HiLo_Busy,
  output logic [STALL_CNT_W-1:0] Stall_Cycles
);

  localparam logic [3:0]             MUL_LOAD = 4'(MULT_LATENCY);
  localparam logic [3:0]             MUL_ONE  = 4'd1;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE  = STALL_CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX  = '1;

  sb_entry_t              id_entry;
  logic                   raw;
  logic                   ex_mul;
  logic                   mem_mul;
  logic                   mbusy;
  logic                   stall;
  logic                   issue;
  logic [3:0]             mul_cnt_reg;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  // Writes to $0 are dropped, so they never enter the scoreboard as valid.
  assign id_entry = '{v:   RegWrite_ID && (Dest_Reg_ID != REG_ZERO),
                      dst: Dest_Reg_ID,
                      mul: Mult_ID};

  hazard_scoreboard #(
    .WRITE_THROUGH (REGFILE_WRITE_THROUGH)
  ) u_scoreboard (
    .clk      (Clk),
    .rst      (Reset),
    .issue    (issue),
    .flush    (PCSrc_MEM),
    .id_entry (id_entry),
    .rs       (Rs_ID),
    .rt       (Rt_ID),
    .uses_rs  (Uses_Rs_ID),
    .uses_rt  (Uses_Rt_ID),
    .raw      (raw),
    .ex_mul   (ex_mul),
    .mem_mul  (mem_mul)
  );

  // HI/LO is busy from the moment a multiply issues until its result lands;
  // a multiply in EX/MEM counts even though it may still be squashed.
  assign mbusy = (mul_cnt_reg != 4'd0) || ex_mul || mem_mul;
  assign stall = raw || ((Mult_ID || MfHiLo_ID) && mbusy);
  assign issue = !stall && !PCSrc_MEM;

  // Multiplier countdown: the multiply commits once it reaches MEM, which
  // is older than any branch resolving that cycle, so a flush never stops it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mul_cnt_reg <= 4'd0;
    end else if (mem_mul) begin
      mul_cnt_reg <= MUL_LOAD;
    end else if (mul_cnt_reg != 4'd0) begin
      mul_cnt_reg <= mul_cnt_reg - MUL_ONE;
    end
  end

  // Count cycles lost to hazards; cycles that flush instead are not stalls.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt_reg <= '0;
    end else if (stall && !PCSrc_MEM && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  // Pipeline-register control with flush taking priority over stall. While
  // Reset is high the inputs are ignored so the pipeline sees plain loads.
  always_comb begin
    PC_Write_En    = 1'b1;
    IF_ID_Write_En = 1'b1;
    IF_ID_Flush    = 1'b0;
    ID_EX_Bubble   = 1'b0;
    EX_MEM_Flush   = 1'b0;
    Mult_Start     = 1'b0;
    Mult_Done      = 1'b0;
    HiLo_Busy      = 1'b0;
    if (!Reset) begin
      if (PCSrc_MEM) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
        EX_MEM_Flush = 1'b1;
      end else if (stall) begin
        PC_Write_En    = 1'b0;
        IF_ID_Write_En = 1'b0;
        ID_EX_Bubble   = 1'b1;
      end
      Mult_Start = mem_mul;
      Mult_Done  = (mul_cnt_reg == MUL_ONE);
      HiLo_Busy  = mbusy;
    end
  end

  assign Stall_Cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Each step drives the ID/MEM
// inputs, pushes the expected outputs to a queue and pops/compares them at
// the falling edge. A second instance without write-through and with a
// 2-bit counter checks stall-counter saturation.
module tb_pipeline_hazard_ctrl;

  logic        Clk;
  logic        Reset;
  logic [4:0]  Rs_ID, Rt_ID, Dest_Reg_ID;
  logic        Uses_Rs_ID, Uses_Rt_ID, RegWrite_ID, Mult_ID, MfHiLo_ID, PCSrc_MEM;
  logic        PC_Write_En, IF_ID_Write_En, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush;
  logic        Mult_Start, Mult_Done, HiLo_Busy;
  logic [31:0] Stall_Cycles;

  logic        s_pcw, s_ifw, s_iff, s_bub, s_exf, s_ms, s_md, s_busy;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  o;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  // Control patterns: {PC_Write_En, IF_ID_Write_En, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush}
  localparam logic [4:0] N5 = 5'b11000;
  localparam logic [4:0] S5 = 5'b00010;
  localparam logic [4:0] F5 = 5'b11111;

  pipeline_hazard_ctrl #(
    .MULT_LATENCY(4), .REGFILE_WRITE_THROUGH(1'b1), .STALL_CNT_W(32)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .Uses_Rs_ID(Uses_Rs_ID), .Uses_Rt_ID(Uses_Rt_ID), .Dest_Reg_ID(Dest_Reg_ID),
    .RegWrite_ID(RegWrite_ID), .Mult_ID(Mult_ID), .MfHiLo_ID(MfHiLo_ID),
    .PCSrc_MEM(PCSrc_MEM), .PC_Write_En(PC_Write_En), .IF_ID_Write_En(IF_ID_Write_En),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Flush(EX_MEM_Flush),
    .Mult_Start(Mult_Start), .Mult_Done(Mult_Done), .HiLo_Busy(HiLo_Busy),
    .Stall_Cycles(Stall_Cycles)
  );

  pipeline_hazard_ctrl #(
    .MULT_LATENCY(4), .REGFILE_WRITE_THROUGH(1'b0), .STALL_CNT_W(2)
  ) dut_sat (
    .Clk(Clk), .Reset(Reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .Uses_Rs_ID(Uses_Rs_ID), .Uses_Rt_ID(Uses_Rt_ID), .Dest_Reg_ID(Dest_Reg_ID),
    .RegWrite_ID(RegWrite_ID), .Mult_ID(Mult_ID), .MfHiLo_ID(MfHiLo_ID),
    .PCSrc_MEM(PCSrc_MEM), .PC_Write_En(s_pcw), .IF_ID_Write_En(s_ifw),
    .IF_ID_Flush(s_iff), .ID_EX_Bubble(s_bub), .EX_MEM_Flush(s_exf),
    .Mult_Start(s_ms), .Mult_Done(s_md), .HiLo_Busy(s_busy),
    .Stall_Cycles(s_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] dst, input logic rw,
                        input logic mul, input logic mf, input logic pc);
    Rs_ID = rs; Rt_ID = rt; Uses_Rs_ID = urs; Uses_Rt_ID = urt;
    Dest_Reg_ID = dst; RegWrite_ID = rw; Mult_ID = mul; MfHiLo_ID = mf;
    PCSrc_MEM = pc;
  endtask

  task automatic push_exp(input string tag, input logic [4:0] pat, input logic ms,
                          input logic md, input logic busy, input logic [31:0] cnt);
    exp_t e;
    e.o   = {pat, ms, md, busy};
    e.cnt = cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    exp_t       e;
    string      t;
    logic [7:0] obs;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {PC_Write_En, IF_ID_Write_En, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush,
           Mult_Start, Mult_Done, HiLo_Busy};
    total++;
    assert (obs === e.o) else begin
      bad++;
      $error("FAIL %s outputs observed=%b expected=%b", t, obs, e.o);
    end
    total++;
    assert (Stall_Cycles === e.cnt) else begin
      bad++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", t, Stall_Cycles, e.cnt);
    end
    $display("step %-18s out=%b cnt=%0d", t, obs, Stall_Cycles);
  endtask

  // Compare at the falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [4:0] pat, input logic ms,
                      input logic md, input logic busy, input logic [31:0] cnt);
    push_exp(tag, pat, ms, md, busy, cnt);
    @(negedge Clk);
    check_now();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset_idle",   N5, 0, 0, 0, 0);
    set_id(3, 0, 1, 0, 0, 0, 1, 1, 1);
    step("reset_pcsrc",  N5, 0, 0, 0, 0);
    Reset = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle",         N5, 0, 0, 0, 0);

    // add $3 then a reader of $3: two stalls with write-through
    set_id(0, 0, 0, 0, 3, 1, 0, 0, 0);
    step("raw_writer",   N5, 0, 0, 0, 0);
    set_id(3, 0, 1, 0, 4, 1, 0, 0, 0);
    step("raw_stall1",   S5, 0, 0, 0, 0);
    step("raw_stall2",   S5, 0, 0, 0, 1);
    step("raw_issue",    N5, 0, 0, 0, 2);

    // $0 destination / $0 sources / unused rt never stall
    set_id(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("zero_dest",    N5, 0, 0, 0, 2);
    set_id(0, 0, 1, 1, 3, 1, 0, 0, 0);
    step("read_r0",      N5, 0, 0, 0, 2);
    set_id(5, 3, 1, 0, 0, 0, 0, 0, 0);
    step("rt_unused",    N5, 0, 0, 0, 2);

    // taken branch overrides a RAW stall on $3 (now in MEM)
    set_id(3, 0, 1, 0, 0, 0, 0, 0, 1);
    step("flush_raw",    F5, 0, 0, 0, 2);
    set_id(3, 0, 1, 0, 0, 0, 0, 0, 0);
    step("post_flush",   N5, 0, 0, 0, 2);

    // mult then mfhi: 6 stall cycles, start 2 after issue, done 4 later
    set_id(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("mult_issue",   N5, 0, 0, 0, 2);
    set_id(0, 0, 0, 0, 8, 1, 0, 1, 0);
    step("mfhi_s1",      S5, 0, 0, 1, 2);
    step("mfhi_s2_start",S5, 1, 0, 1, 3);
    step("mfhi_s3",      S5, 0, 0, 1, 4);
    step("mfhi_s4",      S5, 0, 0, 1, 5);
    step("mfhi_s5",      S5, 0, 0, 1, 6);
    step("mfhi_s6_done", S5, 0, 1, 1, 7);
    step("mfhi_issue",   N5, 0, 0, 0, 8);

    total++;
    assert (s_cnt === 2'b11) else begin
      bad++;
      $error("FAIL sat_counter observed=%0d expected=3", s_cnt);
    end
    $display("step %-18s cnt=%0d", "sat_counter", s_cnt);

    // mult squashed in EX by a taken branch
    set_id(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("mult2_issue",  N5, 0, 0, 0, 8);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("squash",       F5, 0, 0, 1, 8);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("squash_idle1", N5, 0, 0, 0, 8);
    step("squash_idle2", N5, 0, 0, 0, 8);

    // reset mid-multiply with a pending hazard
    set_id(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("mult3_issue",  N5, 0, 0, 0, 8);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mult3_ex",     N5, 0, 0, 1, 8);
    step("mult3_start",  N5, 1, 0, 1, 8);
    set_id(0, 0, 0, 0, 9, 1, 0, 0, 0);
    step("mult3_run",    N5, 0, 0, 1, 8);
    set_id(9, 0, 1, 0, 0, 0, 0, 0, 0);
    push_exp("pre_reset", S5, 0, 0, 1, 8);
    @(negedge Clk);
    check_now();
    #1 Reset = 1'b1;
    #1;
    push_exp("async_reset", N5, 0, 0, 0, 0);
    check_now();
    step("reset_hold",   N5, 0, 0, 0, 0);
    Reset = 1'b0;
    set_id(5, 0, 1, 0, 10, 1, 0, 0, 0);
    step("post_reset",   N5, 0, 0, 0, 0);
    set_id(10, 0, 1, 0, 0, 0, 0, 0, 0);
    step("post_reset_raw", S5, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
